jam_cost_table: RTL and testbench

//  Upstream cost store for the JAM job-assignment engine.

---
 rtl/jam_pkg.sv | 31 +++
 rtl/jam_cost_mem.sv | 37 +++
 rtl/jam_cost_table.sv | 126 ++++++++++++
 tb/tb_jam_cost_table.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jam_pkg.sv
// rtl/jam_pkg.sv - shared sizes, FSM state type and address helper for the JAM cost table (COST_PARITY_EN widens entries)
package jam_pkg;

    localparam int WORKERS = 8;
    localparam int JOBS    = 8;
    localparam int COST_W  = 7;
    localparam int WW      = $clog2(WORKERS);
    localparam int JW      = $clog2(JOBS);
    localparam int DEPTH   = WORKERS * JOBS;
    localparam int AW      = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);

`ifdef COST_PARITY_EN
    localparam int ENTRY_W = COST_W + 1;
`else
    localparam int ENTRY_W = COST_W;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Row-major flat address of worker w, job j.
    function automatic logic [AW-1:0] addr(input logic [WW-1:0] w, input logic [JW-1:0] j);
        return AW'(int'(w) * JOBS + int'(j));
    endfunction

endpackage

// File: rtl/jam_cost_mem.sv
// rtl/jam_cost_mem.sv - cost matrix storage: synchronous write, registered read with enable
module jam_cost_mem
    import jam_pkg::*;
#(
    parameter int DW = ENTRY_W
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem_q [DEPTH];

    // Array write port; contents survive RST so a reset never costs more than a reload.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read register: returns the addressed entry when enabled, zero otherwise.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem_q[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/jam_cost_table.sv
// rtl/jam_cost_table.sv - JAM cost store: host load, lookup, JAM reset/done control (COST_PARITY_EN adds LdPar/ParErr)
module jam_cost_table
    import jam_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              LdStart,
    input  logic              LdValid,
    input  logic [COST_W-1:0] LdData,
    output logic              LdReady,
    output logic [CNT_W-1:0]  LdCount,
    input  logic [WW-1:0]     W,
    input  logic [JW-1:0]     J,
    output logic [COST_W-1:0] Cost,
    output logic              JamRst,
    output logic              TableReady,
    input  logic              JamValid,
    output logic              Done
`ifdef COST_PARITY_EN
    ,
    input  logic              LdPar,
    output logic              ParErr
`endif
);

    state_t state_q;
    state_t state_d;

    logic               ld_accept;
    logic               ld_last;
    logic               rd_en;
    logic [AW-1:0]      rd_addr;
    logic [ENTRY_W-1:0] wr_data;
    logic [ENTRY_W-1:0] rd_word;

    // A restart pulse discards any entry offered in the same cycle.
    assign ld_accept = (state_q == LOAD) && LdValid && !LdStart;
    assign ld_last   = ld_accept && (LdCount == CNT_W'(DEPTH - 1));
    assign rd_en     = (state_q == RUN) || (state_q == DONE);
    assign rd_addr   = addr(W, J);

`ifdef COST_PARITY_EN
    assign wr_data = {LdPar, LdData};
`else
    assign wr_data = LdData;
`endif

    assign Cost = rd_word[COST_W-1:0];

    // Next-state logic; LdStart outranks every other event, including JamValid.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (LdStart) state_d = LOAD;
            end
            LOAD: begin
                if (LdStart)      state_d = LOAD;
                else if (ld_last) state_d = RUN;
            end
            RUN: begin
                if (LdStart)       state_d = LOAD;
                else if (JamValid) state_d = DONE;
            end
            DONE: begin
                if (LdStart) state_d = LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and control outputs, all registered from the next state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            LdReady    <= 1'b0;
            JamRst     <= 1'b1;
            TableReady <= 1'b0;
            Done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            LdReady    <= (state_d == LOAD);
            JamRst     <= !((state_d == RUN) || (state_d == DONE));
            TableReady <= (state_d == RUN) || (state_d == DONE);
            Done       <= (state_d == DONE);
        end
    end

    // Load counter doubles as the write address; it rests at DEPTH once full.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            LdCount <= '0;
        end else if (LdStart) begin
            LdCount <= '0;
        end else if (ld_accept) begin
            LdCount <= LdCount + CNT_W'(1);
        end
    end

    jam_cost_mem #(
        .DW (ENTRY_W)
    ) u_mem (
        .CLK     (CLK),
        .RST     (RST),
        .wr_en   (ld_accept),
        .wr_addr (LdCount[AW-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_word)
    );

`ifdef COST_PARITY_EN
    // Sticky parity error on lookup words; a word read on the LdStart edge is ignored.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ParErr <= 1'b0;
        end else if (LdStart) begin
            ParErr <= 1'b0;
        end else if (rd_en && (^rd_word)) begin
            ParErr <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_jam_cost_table.sv
// tb/tb_jam_cost_table.sv - scoreboard bench for jam_cost_table
module tb_jam_cost_table;
    import jam_pkg::*;

    logic              CLK = 1'b0;
    logic              RST;
    logic              LdStart;
    logic              LdValid;
    logic [COST_W-1:0] LdData;
    logic              LdReady;
    logic [CNT_W-1:0]  LdCount;
    logic [WW-1:0]     W;
    logic [JW-1:0]     J;
    logic [COST_W-1:0] Cost;
    logic              JamRst;
    logic              TableReady;
    logic              JamValid;
    logic              Done;
`ifdef COST_PARITY_EN
    logic              LdPar;
    logic              ParErr;
    logic              par_flip = 1'b0;
    assign LdPar = (^LdData) ^ par_flip;
`endif

    int   n_vec = 0;
    int   n_bad = 0;
    int   exp_q[$];
    int   model[DEPTH];
    logic look_req = 1'b0;
    logic look_vld = 1'b0;

    jam_cost_table dut (
        .CLK        (CLK),
        .RST        (RST),
        .LdStart    (LdStart),
        .LdValid    (LdValid),
        .LdData     (LdData),
        .LdReady    (LdReady),
        .LdCount    (LdCount),
        .W          (W),
        .J          (J),
        .Cost       (Cost),
        .JamRst     (JamRst),
        .TableReady (TableReady),
        .JamValid   (JamValid),
        .Done       (Done)
`ifdef COST_PARITY_EN
        ,
        .LdPar      (LdPar),
        .ParErr     (ParErr)
`endif
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) look_vld <= look_req;

    always @(negedge CLK) begin
        int e;
        if (look_vld) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL cost_lookup: got %0d with no expected entry queued", Cost);
            end else begin
                e = exp_q.pop_front();
                if (32'(Cost) !== e) begin
                    n_bad++;
                    $display("FAIL cost_lookup: got %0d expected %0d", Cost, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic int fdata(input int mode, input int a);
        case (mode)
            0:       return a;
            1:       return (a * 5 + 3) % 128;
            2:       return 63 - a;
            default: return (a * 37 + 11) % 128;
        endcase
    endfunction

    task automatic lookup(input int w, input int j, input int e);
        W        = WW'(w);
        J        = JW'(j);
        look_req = 1'b1;
        exp_q.push_back(e);
        step();
        look_req = 1'b0;
    endtask

    task automatic start_load();
        LdStart = 1'b1;
        step();
        LdStart = 1'b0;
    endtask

    task automatic feed(input int mode, input int from, input int to);
        for (int a = from; a < to; a++) begin
            LdValid  = 1'b1;
            LdData   = COST_W'(fdata(mode, a));
            model[a] = fdata(mode, a);
            step();
        end
        LdValid = 1'b0;
    endtask

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        int cnt;
        int guard;
        int v;
        RST = 1'b1; LdStart = 1'b0; LdValid = 1'b0; LdData = '0;
        W = '0; J = '0; JamValid = 1'b0;
        step();
        chk("rst_ld_ready", 32'(LdReady), 0);
        chk("rst_ld_count", 32'(LdCount), 0);
        chk("rst_cost", 32'(Cost), 0);
        chk("rst_jam_rst", 32'(JamRst), 1);
        chk("rst_table_ready", 32'(TableReady), 0);
        chk("rst_done", 32'(Done), 0);
        RST = 1'b0;
        step();

        // back-to-back load, data = address
        start_load();
        chk("load_ready", 32'(LdReady), 1);
        chk("load_count0", 32'(LdCount), 0);
        feed(0, 0, 63);
        chk("load_count63", 32'(LdCount), 63);
        chk("load_table_ready63", 32'(TableReady), 0);
        chk("load_jam_rst63", 32'(JamRst), 1);
        feed(0, 63, 64);
        chk("load_count64", 32'(LdCount), 64);
        chk("load_table_ready", 32'(TableReady), 1);
        chk("load_jam_rst", 32'(JamRst), 0);
        chk("load_ready_off", 32'(LdReady), 0);

        lookup(3, 5, 29);
        lookup(7, 7, 63);
        lookup(0, 0, 0);
        lookup(1, 0, 8);
        step();

        // LdValid outside LOAD must be ignored
        LdValid = 1'b1; LdData = 7'h7F;
        step(); step();
        LdValid = 1'b0;
        chk("run_ld_count", 32'(LdCount), 64);
        lookup(2, 2, 18);

        // JamValid -> DONE, sticky, then reload from DONE
        JamValid = 1'b1;
        step();
        JamValid = 1'b0;
        chk("done_set", 32'(Done), 1);
        chk("done_jam_rst", 32'(JamRst), 0);
        chk("done_table_ready", 32'(TableReady), 1);
        step();
        chk("done_sticky", 32'(Done), 1);
        lookup(4, 4, 36);
        start_load();
        chk("reload_jam_rst", 32'(JamRst), 1);
        chk("reload_done", 32'(Done), 0);
        chk("reload_table_ready", 32'(TableReady), 0);
        chk("reload_count", 32'(LdCount), 0);
        lookup(3, 5, 0);

        // restart mid-load discards the same-cycle entry
        feed(1, 0, 5);
        chk("partial_count", 32'(LdCount), 5);
        LdStart = 1'b1; LdValid = 1'b1; LdData = 7'h7F;
        step();
        LdStart = 1'b0; LdValid = 1'b0;
        chk("restart_count", 32'(LdCount), 0);
        chk("restart_ready", 32'(LdReady), 1);

        // gapped load with random LdValid
        cnt = 0;
        guard = 0;
        while (cnt < DEPTH && guard < 1000) begin
            v = int'($urandom_range(0, 1));
            LdValid = v[0];
            if (v != 0) begin
                LdData     = COST_W'(fdata(1, cnt));
                model[cnt] = fdata(1, cnt);
                cnt++;
            end else begin
                LdData = 7'h7F;
            end
            step();
            guard++;
        end
        LdValid = 1'b0;
        if (guard >= 1000) chk("gap_load_budget", 32'(cnt), DEPTH);
        chk("gap_count", 32'(LdCount), 64);
        chk("gap_table_ready", 32'(TableReady), 1);
        for (int a = 0; a < DEPTH; a++) lookup(a / JOBS, a % JOBS, model[a]);
        step();

        // asynchronous reset mid-load, then full reload
        start_load();
        feed(2, 0, 20);
        chk("mid_count20", 32'(LdCount), 20);
        RST = 1'b1;
        #1;
        chk("async_rst_count", 32'(LdCount), 0);
        chk("async_rst_jam_rst", 32'(JamRst), 1);
        chk("async_rst_ready", 32'(LdReady), 0);
        step();
        RST = 1'b0;
        LdValid = 1'b1; LdData = 7'h7F;
        step();
        LdValid = 1'b0;
        chk("idle_ignore_count", 32'(LdCount), 0);
        chk("idle_table_ready", 32'(TableReady), 0);
        start_load();
        feed(2, 0, 64);
        chk("reload2_table_ready", 32'(TableReady), 1);
        chk("reload2_jam_rst", 32'(JamRst), 0);
        lookup(0, 0, 63);
        lookup(2, 3, 44);
        lookup(7, 7, 0);
        step();

        // simultaneous LdStart & JamValid in RUN: LdStart wins
        LdStart = 1'b1; JamValid = 1'b1;
        step();
        LdStart = 1'b0; JamValid = 1'b0;
        chk("race_done", 32'(Done), 0);
        chk("race_jam_rst", 32'(JamRst), 1);
        chk("race_ready", 32'(LdReady), 1);
        step();
        chk("race_done_later", 32'(Done), 0);
        feed(3, 0, 64);
        lookup(6, 1, fdata(3, 49));
        step();

`ifdef COST_PARITY_EN
        start_load();
        for (int a = 0; a < DEPTH; a++) begin
            par_flip = (a == 10);
            LdValid  = 1'b1;
            LdData   = COST_W'(a);
            step();
        end
        LdValid = 1'b0; par_flip = 1'b0;
        chk("par_clean", 32'(ParErr), 0);
        lookup(1, 2, 10);
        W = '0; J = '0;
        step();
        chk("par_err_set", 32'(ParErr), 1);
        step();
        chk("par_err_sticky", 32'(ParErr), 1);
        start_load();
        chk("par_err_clear", 32'(ParErr), 0);
`endif

        step(); step();
        chk("scoreboard_drain", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
